// File: rtl/mbf_subband_writer.sv
// Output stage of the multi-bank filter: decimates the y/z subbands by 2, buffers kept
// pairs in a small FIFO and writes them nibble-serially into a 1024x4 result RAM.
module mbf_subband_writer #(
    parameter int unsigned N_IN       = 528,
    parameter int unsigned Z_BASE     = 512,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       y_valid,
    input  logic       z_valid,
    input  logic [7:0] y,
    input  logic [7:0] z,
    output logic       ram_cen,
    output logic       ram_wen,
    output logic [9:0] ram_a,
    output logic [3:0] ram_d,
    output logic       done,
    output logic       err_ovf,
    output logic       err_sync
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, WYL, WYH, WZL, WZH, DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    in_cnt_q;
    logic [9:0]    k_q, k_d;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic [9:0]    a_q, a_d;
    logic [3:0]    d_q, d_d;
    logic          ovf_q, sync_q;

    logic          fifo_full, fifo_empty;
    logic          accept, keep, push, pop, ovf_set;
    logic [9:0]    addr_base;

    assign fifo_full  = (count_q == FIFO_DEPTH[AW:0]);
    assign fifo_empty = (count_q == '0);
    assign accept     = y_valid & z_valid & (in_cnt_q < N_IN[9:0]);
    assign keep       = accept & ~in_cnt_q[0];
    // A pop in the same cycle frees the slot, so push-while-full is fine then.
    assign push       = keep & (~fifo_full | pop);
    assign ovf_set    = keep & fifo_full & ~pop;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WYL;
                end else if (in_cnt_q == N_IN[9:0]) begin
                    state_d = DONE;
                end
            end
            WYL: state_d = WYH;
            WYH: state_d = WZL;
            WZL: state_d = WZH;
            WZH: begin
                k_d = k_q + 10'd1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WYL;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // RAM outputs are registered from the next state so each write is presented
    // during its own state cycle and committed at the edge that leaves it.
    always_comb begin
        hold_d    = pop ? mem_q[rd_ptr_q] : hold_q;
        addr_base = {k_d[8:0], 1'b0};
        cen_d     = 1'b1;
        wen_d     = 1'b1;
        a_d       = a_q;
        d_d       = d_q;
        unique case (state_d)
            WYL: begin
                cen_d = 1'b0;
                wen_d = 1'b0;
                a_d   = addr_base;
                d_d   = hold_d[3:0];
            end
            WYH: begin
                cen_d = 1'b0;
                wen_d = 1'b0;
                a_d   = addr_base + 10'd1;
                d_d   = hold_d[7:4];
            end
            WZL: begin
                cen_d = 1'b0;
                wen_d = 1'b0;
                a_d   = Z_BASE[9:0] + addr_base;
                d_d   = hold_d[11:8];
            end
            WZH: begin
                cen_d = 1'b0;
                wen_d = 1'b0;
                a_d   = Z_BASE[9:0] + addr_base + 10'd1;
                d_d   = hold_d[15:12];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            hold_q  <= '0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            a_q     <= a_d;
            d_q     <= d_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt_q <= '0;
            ovf_q    <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            if (accept)
                in_cnt_q <= in_cnt_q + 10'd1;
            if (ovf_set)
                ovf_q <= 1'b1;
            if (y_valid ^ z_valid)
                sync_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {z, y};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign ram_cen  = cen_q;
    assign ram_wen  = wen_q;
    assign ram_a    = a_q;
    assign ram_d    = d_q;
    assign done     = (state_q == DONE);
    assign err_ovf  = ovf_q;
    assign err_sync = sync_q;

endmodule

// File: tb/tb_mbf_subband_writer.sv
// Bench for mbf_subband_writer: directed scenarios with random sample data, checked
// every cycle against a queue-based transaction model of the subband writer.
module tb_mbf_subband_writer;

    localparam int N_IN       = 528;
    localparam int Z_BASE     = 512;
    localparam int FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       y_valid = 1'b0, z_valid = 1'b0;
    logic [7:0] y = '0, z = '0;
    logic       ram_cen, ram_wen, done, err_ovf, err_sync;
    logic [9:0] ram_a;
    logic [3:0] ram_d;

    mbf_subband_writer #(.N_IN(N_IN), .Z_BASE(Z_BASE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .y_valid(y_valid), .z_valid(z_valid), .y(y), .z(z),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_a(ram_a), .ram_d(ram_d),
        .done(done), .err_ovf(err_ovf), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: pending pairs queue plus the nibble phase (0 idle, 1..4 writing) of the current pair.
    logic [15:0] m_q[$];
    logic [15:0] m_cur;
    int          m_in_cnt, m_phase, m_k, m_a, m_d;
    bit          m_ovf, m_sync, m_done;

    logic [3:0]  shadow [1024];
    int          wcount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur = '0; m_in_cnt = 0; m_phase = 0; m_k = 0; m_a = 0; m_d = 0;
        m_ovf = 0; m_sync = 0; m_done = 0;
    endtask

    task automatic model_edge(input logic yv, input logic zv, input logic [7:0] yd, input logic [7:0] zd);
        bit accept, keep, pop;
        int base;
        accept = yv && zv && (m_in_cnt < N_IN);
        keep   = accept && (m_in_cnt % 2 == 0);
        pop    = !m_done && (m_phase == 0 || m_phase == 4) && (m_q.size() > 0);
        if (!m_done && m_phase == 0 && m_q.size() == 0 && m_in_cnt == N_IN) m_done = 1;
        if (m_phase == 4) m_k++;
        if (pop) m_cur = m_q.pop_front();
        if (keep) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back({zd, yd});
            else m_ovf = 1;
        end
        if (pop) m_phase = 1;
        else if (m_phase >= 1 && m_phase <= 3) m_phase++;
        else m_phase = 0;
        base = 2 * m_k;
        case (m_phase)
            1: begin m_a = base % 1024;              m_d = int'(m_cur[3:0]);   end
            2: begin m_a = (base + 1) % 1024;        m_d = int'(m_cur[7:4]);   end
            3: begin m_a = (Z_BASE + base) % 1024;     m_d = int'(m_cur[11:8]);  end
            4: begin m_a = (Z_BASE + base + 1) % 1024; m_d = int'(m_cur[15:12]); end
            default: ;
        endcase
        if (accept) m_in_cnt++;
        if (yv ^ zv) m_sync = 1;
    endtask

    task automatic check_outputs();
        chk("ram_cen",  32'(ram_cen),  32'(m_phase == 0));
        chk("ram_wen",  32'(ram_wen),  32'(m_phase == 0));
        chk("ram_a",    32'(ram_a),    32'(m_a));
        chk("ram_d",    32'(ram_d),    32'(m_d));
        chk("done",     32'(done),     32'(m_done));
        chk("err_ovf",  32'(err_ovf),  32'(m_ovf));
        chk("err_sync", 32'(err_sync), 32'(m_sync));
    endtask

    task automatic step(input logic yv, input logic zv, input logic [7:0] yd, input logic [7:0] zd);
        y_valid = yv; z_valid = zv; y = yd; z = zd;
        if (!ram_cen && !ram_wen) begin
            shadow[ram_a] = ram_d;
            wcount++;
        end
        @(posedge clk);
        model_edge(yv, zv, yd, zd);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        y_valid = 1'b0; z_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        for (int i = 0; i < 1024; i++) shadow[i] = 4'hF;
        wcount = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] ry, rz;

        // Reset state
        do_reset();
        chk("reset_cen", 32'(ram_cen), 32'd1);
        chk("reset_done", 32'(done), 32'd0);

        // Single pair: four nibble writes then idle
        step(1'b1, 1'b1, 8'h3C, 8'hA5);
        idle(6);
        chk("single_a0",   32'(shadow[0]),   32'hC);
        chk("single_a1",   32'(shadow[1]),   32'h3);
        chk("single_a512", 32'(shadow[512]), 32'h5);
        chk("single_a513", 32'(shadow[513]), 32'hA);
        chk("single_wcnt", 32'(wcount), 32'd4);

        // Decimation at one pair per two cycles
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'(i), 8'(8'h80 + i));
            idle(1);
        end
        idle(20);
        for (int i = 0; i < 8; i++)
            chk("decim_ylo", 32'(shadow[i]), (i % 2 == 0) ? 32'(i) : 32'd0);
        chk("decim_zlo2", 32'(shadow[Z_BASE + 2]), 32'h2);
        chk("decim_zhi2", 32'(shadow[Z_BASE + 3]), 32'h8);
        chk("decim_ovf", 32'(err_ovf), 32'd0);

        // Back-to-back input overflows the FIFO
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        idle(60);
        chk("burst_ovf", 32'(err_ovf), 32'd1);

        // Sync error: mismatched valids are not accepted
        do_reset();
        step(1'b1, 1'b0, 8'h11, 8'h22);
        idle(2);
        chk("sync_flag", 32'(err_sync), 32'd1);
        chk("sync_nowr", 32'(wcount), 32'd0);
        step(1'b1, 1'b1, 8'h5A, 8'hC3);
        idle(6);
        chk("sync_k0", 32'(shadow[0]), 32'hA);
        chk("sync_sticky", 32'(err_sync), 32'd1);

        // Reset asserted during WYH
        do_reset();
        step(1'b1, 1'b1, 8'h77, 8'h66);
        idle(2);
        chk("pre_rst_wyh_a", 32'(ram_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_cen", 32'(ram_cen), 32'd1);
        chk("rst_wen", 32'(ram_wen), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        model_reset();
        for (int i = 0; i < 1024; i++) shadow[i] = 4'hF;
        wcount = 0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 8'h9E, 8'h4D);
        idle(6);
        chk("rst_new_k0", 32'(shadow[0]), 32'hE);
        chk("rst_new_z",  32'(shadow[Z_BASE + 1]), 32'h4);

        // Full frame: 512 pairs at 2-cycle rate then a 16-pair 1-per-cycle tail
        do_reset();
        for (int i = 0; i < 512; i++) begin
            ry = 8'($urandom); rz = 8'($urandom);
            step(1'b1, 1'b1, ry, rz);
            idle(1);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        idle(120);
        chk("frame_done", 32'(done), 32'd1);
        chk("frame_writes", 32'(wcount), 32'd1056);
        chk("frame_ovf", 32'(err_ovf), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        idle(4);
        chk("frame_ignored", 32'(wcount), 32'd1056);
        chk("frame_done_hold", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mbf_subband_writer.md
Name: mbf_subband_writer

Overview:
- Downstream stage of the multi-bank filter. Consumes the lowpass (y) and highpass (z) sample streams together with their valid strobes.
- Decimates both subbands by 2, buffers the kept sample pairs in a small FIFO, and writes them nibble-serially into a 1024x4 result RAM.
- Asserts done once the whole frame has been committed.
- Its RAM interface mirrors the 4-bit ROM interface on the filter's input side.

Parameters:
- N_IN, 528, number of input sample pairs per frame (512 data + 16 flush)
- Z_BASE, 512, RAM nibble address where the z subband region starts
- FIFO_DEPTH, 8, number of {z,y} entries in the buffer FIFO (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- y_valid  in  1  lowpass sample valid
- z_valid  in  1  highpass sample valid
- y  in  8  lowpass sample, two's complement
- z  in  8  highpass sample, two's complement
- ram_cen  out  1  RAM chip enable, active low
- ram_wen  out  1  RAM write enable, active low
- ram_a  out  10  RAM nibble address
- ram_d  out  4  RAM write data
- done  out  1  frame fully written (level)
- err_ovf  out  1  sticky: a kept pair was dropped because the FIFO was full
- err_sync  out  1  sticky: y_valid != z_valid in some cycle

Behaviour:
- Clock and reset: reset, asynchronous, active-high; clock clk. All state is reset on reset.
- Reset values: ram_cen=1, ram_wen=1, ram_a=0, ram_d=0, done=0, err_ovf=0, err_sync=0. in_cnt=0, k=0, FIFO empty, FSM in IDLE.
- Input accept:
  - A pair is accepted at a rising edge when y_valid & z_valid = 1 and in_cnt < N_IN.
  - in_cnt (10 bit) increments on every accept.
  - Accepts beyond N_IN are ignored without error.
- Mismatched valids: if y_valid ^ z_valid = 1, set err_sync. The pair is not accepted and in_cnt does not change.
- Decimation: only accepted pairs with even in_cnt (before increment) are kept; index 0 is kept. A kept pair pushes {z,y} into the FIFO.
- FIFO full: a push when full drops the new pair and sets err_ovf. Existing contents are unchanged.
- Push and pop in the same cycle when full is legal: count is unchanged and no overflow is flagged.
- Writer FSM states: IDLE, WYL, WYH, WZL, WZH, DONE.
  - IDLE -> WYL when FIFO non-empty. Pop the head into a 16-bit hold register.
  - IDLE -> DONE when in_cnt == N_IN and FIFO empty.
  - WYL -> WYH -> WZL -> WZH, one cycle each, unconditional.
  - WZH -> WYL with a pop if FIFO non-empty; else IDLE. k increments on leaving WZH.
  - DONE is absorbing until reset.
- Writes per state (one nibble write per cycle: ram_cen=0, ram_wen=0):
  - WYL: a=2k, d=y[3:0]
  - WYH: a=2k+1, d=y[7:4]
  - WZL: a=Z_BASE+2k, d=z[3:0]
  - WZH: a=Z_BASE+2k+1, d=z[7:4]
  - In IDLE and DONE: ram_cen=1, ram_wen=1, and ram_a/ram_d hold their last values.
- Address arithmetic is 10-bit and wraps modulo 1024. No range check.
- RAM outputs are driven from registers only, with no combinational path from y, z or the valid inputs.
- Latency: a pair pushed at edge E with FSM IDLE and FIFO empty moves the FSM to WYL at edge E+1. Its four nibble writes are committed at edges E+2..E+5.
- Throughput: one kept pair per 4 cycles. Input every 2 cycles is sustained indefinitely. Input every cycle (the filter's flush phase) grows the FIFO by one entry per 4 cycles.
- done = 1 exactly while the FSM is in DONE.
- Reset mid-frame: aborts any write in progress. Outputs go to reset values immediately (asynchronous). The FIFO and counters are cleared.

Test Plan:
- Single pair: reset, y=8'h3C, z=8'hA5 valid for 1 cycle at edge E -> writes (0,C),(1,3),(512,5),(513,A) at edges E+2..E+5. ram_cen/ram_wen are back to 1 at the next cycle.
- Decimation at 1 pair per 2 cycles: 8 pairs with y=i, z=8'h80+i for i=0..7 -> only i=0,2,4,6 are stored, at k=0..3. Addresses 0..7 hold y nibbles 0,0,2,0,4,0,6,0. err_ovf stays 0.
- Back-to-back input with FIFO_DEPTH=8: 40 consecutive valid cycles -> 20 kept pairs. The FIFO fills and err_ovf=1. The stored pairs are exactly the first N accepted ones and no RAM write is corrupted.
- Full frame with N_IN=528 at 2-cycle rate plus a 16-cycle 1-per-cycle tail -> 264 pairs written and k ends at 264. done rises 1 cycle after the last WZH and stays high. Further valids are ignored.
- Sync error: y_valid=1, z_valid=0 for 1 cycle -> err_sync=1 sticky, in_cnt unchanged, no write.
- Reset asserted during WYH -> ram_cen=1, ram_wen=1, done=0 immediately. After release, a new pair is written at k=0.
